// File: rtl/sdram_pixel_fifo_pkg.sv
// Shared types and colour helper for the SDRAM pixel FIFO.
// Optional build macro PIX_BITREP_EN selects MSB-replication colour expansion.
package sdram_pix_pkg;

    localparam int SDRAM_BURST_LEN = 8;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fifo_state_e;

    function automatic rgb888_t rgb565_to_888(input rgb565_t px);
        rgb888_t o;
`ifdef PIX_BITREP_EN
        o.r = {px.r, px.r[4:2]};
        o.g = {px.g, px.g[5:4]};
        o.b = {px.b, px.b[4:2]};
`else
        o.r = {px.r, 3'b000};
        o.g = {px.g, 2'b00};
        o.b = {px.b, 3'b000};
`endif
        return o;
    endfunction

endpackage

// File: rtl/sdram_pixel_fifo_mem.sv
// Simple dual-port DEPTH x DATA_W array: synchronous write, registered read.
module pix_fifo_mem #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds the last popped word between pops
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sdram_pixel_fifo.sv
// Pixel FIFO between the SDRAM read burst stream and display scan-out.
// Colour expansion mode is selected by PIX_BITREP_EN (see sdram_pix_pkg).
module sdram_pixel_fifo
    import sdram_pix_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = SDRAM_BURST_LEN,
    parameter int DATA_W    = 16
) (
    input  logic                     ck,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     burst_req,
    input  logic                     flush,
    input  logic                     pix_req,
    output logic                     pix_valid,
    output logic [23:0]              pix_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN) + 1;

    fifo_state_e       state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic [CW-1:0]     rx_count_q;
    logic              burst_req_q;
    logic              pix_valid_q;
    logic              underflow_q;
    logic              overflow_q;

    logic              full_s;
    logic              empty_s;
    logic              store_en_s;
    logic              push_s;
    logic              pop_s;
    logic              space_s;
    logic              burst_done_s;
    logic [CW-1:0]     rx_inc_s;
    logic [DATA_W-1:0] mem_rd_s;

    assign full_s       = (level_q == LW'(DEPTH));
    assign empty_s      = (level_q == {LW{1'b0}});
    // Words arriving during DRAIN belong to the discarded burst
    assign store_en_s   = in_valid && !flush && (state_q != DRAIN);
    assign push_s       = store_en_s && !full_s;
    assign pop_s        = pix_req && !flush && !empty_s;
    assign space_s      = ((LW'(DEPTH) - level_q) >= LW'(BURST_LEN));
    assign rx_inc_s     = rx_count_q + CW'(1);
    assign burst_done_s = in_valid && (rx_inc_s == CW'(BURST_LEN));

    pix_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk_i     (ck),
        .rst_n_i   (reset_n),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_en_i   (pop_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_s)
    );

    // Pointers, occupancy, output valid and sticky error flags
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            pix_valid_q <= pop_s;
            if (pix_req && empty_s) begin
                underflow_q <= 1'b1;
            end
            if (store_en_s && full_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Burst request FSM: at most one burst outstanding
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rx_count_q  <= {CW{1'b0}};
            burst_req_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!flush && space_s) begin
                        burst_req_q <= 1'b1;
                        rx_count_q  <= {CW{1'b0}};
                        state_q     <= WAIT;
                    end else begin
                        burst_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    burst_req_q <= 1'b0;
                    if (in_valid) begin
                        rx_count_q <= rx_inc_s;
                    end
                    // A completing burst wins over flush so DRAIN never waits forever
                    if (burst_done_s) begin
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    burst_req_q <= 1'b0;
                    if (in_valid) begin
                        rx_count_q <= rx_inc_s;
                    end
                    if (burst_done_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    burst_req_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign burst_req = burst_req_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = rgb565_to_888(rgb565_t'(mem_rd_s));
    assign level     = level_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_sdram_pixel_fifo.sv
// Directed, table-driven bench for sdram_pixel_fifo (both PIX_BITREP_EN builds).
module tb_sdram_pixel_fifo;

`ifdef PIX_BITREP_EN
    localparam logic [23:0] EXP_F800 = 24'hFF0000;
    localparam logic [23:0] EXP_FFFF = 24'hFFFFFF;
    localparam logic [23:0] EXP_07E0 = 24'h00FF00;
`else
    localparam logic [23:0] EXP_F800 = 24'hF80000;
    localparam logic [23:0] EXP_FFFF = 24'hF8FCF8;
    localparam logic [23:0] EXP_07E0 = 24'h00FC00;
`endif

    typedef struct packed {
        logic        iv;
        logic [15:0] d;
        logic        req;
        logic        ev;
        logic [23:0] ed;
        logic [6:0]  el;
        logic        euf;
    } vec_t;

    logic        ck = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        burst_req;
    logic        flush;
    logic        pix_req;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic [6:0]  level;
    logic        underflow;
    logic        overflow;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sb [$];
    vec_t        tbl [14];

    sdram_pixel_fifo dut (
        .ck        (ck),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .burst_req (burst_req),
        .flush     (flush),
        .pix_req   (pix_req),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .level     (level),
        .underflow (underflow),
        .overflow  (overflow)
    );

    always #5 ck = ~ck;

    function automatic logic [23:0] exp888(input logic [15:0] w);
`ifdef PIX_BITREP_EN
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
`else
        return {w[15:11], 3'b000, w[10:5], 2'b00, w[4:0], 3'b000};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge ck);
        in_valid = 1'b0;
    endtask

    task automatic count_bursts(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ck);
            if (burst_req) cnt++;
        end
    endtask

    initial begin
        int cnt;
        logic found;
        logic [15:0] w;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        flush    = 1'b0;
        pix_req  = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{iv: 1'b0, d: 16'h0000, req: 1'b1, ev: 1'b1, ed: EXP_F800,
                       el: 7'(7 - i), euf: 1'b0};
        end
        tbl[8]  = '{iv: 1'b0, d: 16'h0000, req: 1'b1, ev: 1'b0, ed: EXP_F800, el: 7'd0, euf: 1'b1};
        tbl[9]  = '{iv: 1'b0, d: 16'h0000, req: 1'b0, ev: 1'b0, ed: EXP_F800, el: 7'd0, euf: 1'b1};
        tbl[10] = '{iv: 1'b1, d: 16'hFFFF, req: 1'b0, ev: 1'b0, ed: EXP_F800, el: 7'd1, euf: 1'b1};
        tbl[11] = '{iv: 1'b0, d: 16'h0000, req: 1'b1, ev: 1'b1, ed: EXP_FFFF, el: 7'd0, euf: 1'b1};
        tbl[12] = '{iv: 1'b1, d: 16'h07E0, req: 1'b0, ev: 1'b0, ed: EXP_FFFF, el: 7'd1, euf: 1'b1};
        tbl[13] = '{iv: 1'b0, d: 16'h0000, req: 1'b1, ev: 1'b1, ed: EXP_07E0, el: 7'd0, euf: 1'b1};

        // Reset values
        repeat (3) @(negedge ck);
        check("rst_burst_req", 32'(burst_req), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // One burst request right after release
        reset_n = 1'b1;
        @(negedge ck);
        check("first_burst_req", 32'(burst_req), 32'd1);
        @(negedge ck);
        check("first_burst_pulse_end", 32'(burst_req), 32'd0);

        // Fill the FIFO burst by burst with words 1..64
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < 8; i++) feed(16'(b * 8 + i + 1));
            check($sformatf("fill%0d_level", b), 32'(level), 32'(8 * (b + 1)));
            check($sformatf("fill%0d_no_req_yet", b), 32'(burst_req), 32'd0);
            if (b < 7) begin
                @(negedge ck);
                check($sformatf("fill%0d_next_burst", b), 32'(burst_req), 32'd1);
            end
        end
        count_bursts(10, cnt);
        check("full_no_burst", 32'(cnt), 32'd0);

        // Overflow: 8 extra words at level 64 are dropped
        for (int i = 0; i < 8; i++) feed(16'hDEAD);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd64);

        // Drain 8 words: oldest first, burst only once level reaches 56
        for (int i = 0; i < 8; i++) begin
            pix_req = 1'b1;
            @(negedge ck);
            pix_req = 1'b0;
            check($sformatf("pop%0d_valid", i), 32'(pix_valid), 32'd1);
            check($sformatf("pop%0d_data", i), 32'(pix_data), 32'(exp888(16'(i + 1))));
            check($sformatf("pop%0d_level", i), 32'(level), 32'(63 - i));
            check($sformatf("pop%0d_no_burst", i), 32'(burst_req), 32'd0);
        end
        @(negedge ck);
        check("pop_pix_valid_drops", 32'(pix_valid), 32'd0);
        check("burst_at_56", 32'(burst_req), 32'd1);

        // Flush after 3 of 8 burst words; remaining 5 are drained
        for (int i = 0; i < 3; i++) feed(16'h0100 + 16'(i));
        check("pre_flush_level", 32'(level), 32'd59);
        flush = 1'b1;
        @(negedge ck);
        flush = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_ovf_clear", 32'(overflow), 32'd0);
        check("flush_pix_valid", 32'(pix_valid), 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            feed(16'h0BAD);
            if (burst_req) cnt++;
        end
        check("drain_level", 32'(level), 32'd0);
        check("drain_no_burst", 32'(cnt), 32'd0);
        @(negedge ck);
        check("burst_after_drain", 32'(burst_req), 32'd1);

        // One burst of pure red, then table-driven pops and colour checks
        for (int i = 0; i < 8; i++) feed(16'hF800);
        check("red_level", 32'(level), 32'd8);
        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].iv;
            in_data  = tbl[i].d;
            pix_req  = tbl[i].req;
            @(negedge ck);
            check($sformatf("vec%0d_valid", i), 32'(pix_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_data", i), 32'(pix_data), 32'(tbl[i].ed));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].el));
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(tbl[i].euf));
        end
        in_valid = 1'b0;
        pix_req  = 1'b0;

        // Advance pointers, settle at level 20, then push+pop across the 63->0 wrap
        for (int k = 0; k < 50; k++) begin
            w = 16'h3000 + 16'(k);
            sb.push_back(w);
            feed(w);
        end
        check("sb_fill_level", 32'(level), 32'd50);
        for (int k = 0; k < 30; k++) begin
            pix_req = 1'b1;
            @(negedge ck);
            w = sb.pop_front();
            check($sformatf("sb_pop%0d_data", k), 32'(pix_data), 32'(exp888(w)));
        end
        pix_req = 1'b0;
        check("sb_level_20", 32'(level), 32'd20);
        for (int k = 0; k < 30; k++) begin
            w = 16'h4000 + 16'(k);
            sb.push_back(w);
            in_valid = 1'b1;
            in_data  = w;
            pix_req  = 1'b1;
            @(negedge ck);
            w = sb.pop_front();
            check($sformatf("pp%0d_valid", k), 32'(pix_valid), 32'd1);
            check($sformatf("pp%0d_data", k), 32'(pix_data), 32'(exp888(w)));
            check($sformatf("pp%0d_level", k), 32'(level), 32'd20);
        end
        in_valid = 1'b0;
        pix_req  = 1'b0;

        // Reach the first cycle of WAIT, take two words, then reset asynchronously
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h5000 + 16'(i);
            @(negedge ck);
            if (burst_req) found = 1'b1;
        end
        in_valid = 1'b0;
        check("wait_entry_seen", 32'(found), 32'd1);
        feed(16'h6000);
        feed(16'h6001);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_burst_req", 32'(burst_req), 32'd0);
        check("arst_pix_valid", 32'(pix_valid), 32'd0);
        check("arst_pix_data", 32'(pix_data), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_underflow", 32'(underflow), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        @(negedge ck);
        reset_n = 1'b1;
        @(negedge ck);
        check("arst_fresh_burst", 32'(burst_req), 32'd1);
        count_bursts(10, cnt);
        check("arst_single_burst", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
